// File: rtl/frame_sched_if.sv
// Frame scheduler bundle: raw sync/pixel-valid and decision inputs in, gated stream and statistics out.
interface frame_sched_if #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
);
  logic             enable;
  logic [DIV_W-1:0] div;
  logic             enc_busy;
  logic             fifo_afull;
  logic             pvalid_in;
  logic             vsync_in;
  logic             pvalid_out;
  logic             vsync_out;
  logic [1:0]       state;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             sync_lost;

  modport master (
    output enable, div, enc_busy, fifo_afull, pvalid_in, vsync_in,
    input  pvalid_out, vsync_out, state, frame_cnt, drop_cnt, sync_lost
  );

  modport slave (
    input  enable, div, enc_busy, fifo_afull, pvalid_in, vsync_in,
    output pvalid_out, vsync_out, state, frame_cnt, drop_cnt, sync_lost
  );
endinterface

// File: rtl/frame_sched.sv
// Per-frame forward/suppress decision at each vsync rising edge; gated outputs lag inputs by 1 cycle.
// Optional sync-loss watchdog enabled by defining FRAME_SCHED_WDOG_EN.
module frame_sched #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
`ifdef FRAME_SCHED_WDOG_EN
  ,
  parameter int WDOG_W = 24
`endif
) (
  input logic          clk,
  input logic          rst_n,
  frame_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next_state;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] w_next_phase;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_vsync_d;
  logic             r_armed;
  logic             r_pvalid_out;
  logic             r_vsync_out;
  logic             w_vrise;
  logic             w_inc_frame;
  logic             w_inc_drop;
  logic             w_pass_next;
  logic             w_wdog_full;

  // r_armed masks the first cycle after reset so a vsync level already high is not a rising edge.
  assign w_vrise = bus.vsync_in & ~r_vsync_d & r_armed;

`ifdef FRAME_SCHED_WDOG_EN
  logic [WDOG_W-1:0] r_wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_vrise) begin
      r_wdog <= '0;
    end else if (r_wdog != '1) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_wdog_full = (r_wdog == '1);
`else
  assign w_wdog_full = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
      r_vsync_d    <= 1'b0;
      r_armed      <= 1'b0;
      r_pvalid_out <= 1'b0;
      r_vsync_out  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_phase      <= w_next_phase;
      r_vsync_d    <= bus.vsync_in;
      r_armed      <= 1'b1;
      r_pvalid_out <= bus.pvalid_in & w_pass_next;
      r_vsync_out  <= bus.vsync_in & w_pass_next;
      if (w_inc_frame && (r_frame_cnt != CNT_MAX)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_inc_drop && (r_drop_cnt != CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_inc_frame  = 1'b0;
    w_inc_drop   = 1'b0;
    if (w_vrise) begin
      if (!bus.enable) begin
        w_next_state = ST_IDLE;
        w_next_phase = '0;
      end else if (r_phase != '0) begin
        // Decimated frame; >= lets a shrunken div wrap phase immediately.
        w_next_state = ST_SKIP;
        w_next_phase = (r_phase >= bus.div) ? '0 : r_phase + 1'b1;
      end else if (bus.enc_busy || bus.fifo_afull) begin
        // Phase stays 0 so the following frame retries.
        w_next_state = ST_SKIP;
        w_inc_drop   = 1'b1;
      end else begin
        w_next_state = ST_PASS;
        w_inc_frame  = 1'b1;
        w_next_phase = (bus.div == '0) ? '0 : DIV_W'(1);
      end
    end else if (w_wdog_full) begin
      w_next_state = ST_IDLE;
      w_next_phase = '0;
    end
  end

  always_comb begin
    w_pass_next = (w_next_state == ST_PASS);
  end

  assign bus.pvalid_out = r_pvalid_out;
  assign bus.vsync_out  = r_vsync_out;
  assign bus.state      = r_state;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.sync_lost  = w_wdog_full;

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: directed scenarios plus randomized frames against a frame-level reference model.
module tb_frame_sched;
  localparam int DIV_W   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  frame_sched_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  frame_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 IDLE, 1 PASS, 2 SKIP; phase counts frames since the last forwarded one.
  int m_state  = 0;
  int m_phase  = 0;
  int m_frames = 0;
  int m_drops  = 0;
  bit m_last_vs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_decide();
    if (!bus.enable) begin
      m_state = 0;
      m_phase = 0;
    end else if (m_phase != 0) begin
      m_state = 2;
      m_phase = (m_phase >= int'(bus.div)) ? 0 : m_phase + 1;
    end else if (bus.enc_busy || bus.fifo_afull) begin
      m_state = 2;
      if (m_drops < CNT_MAX) m_drops++;
    end else begin
      m_state = 1;
      if (m_frames < CNT_MAX) m_frames++;
      m_phase = (bus.div == 0) ? 0 : 1;
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_phase   = 0;
    m_frames  = 0;
    m_drops   = 0;
    m_last_vs = bus.vsync_in;
  endtask

  // Called at a falling edge: applies inputs for one cycle and checks the registered outputs.
  task automatic step(input logic pv, input logic vs);
    bus.pvalid_in = pv;
    bus.vsync_in  = vs;
    if (vs && !m_last_vs) model_decide();
    m_last_vs = vs;
    @(negedge clk);
    check("pvalid_out", {31'd0, bus.pvalid_out}, {31'd0, pv && (m_state == 1)});
    check("vsync_out", {31'd0, bus.vsync_out}, {31'd0, vs && (m_state == 1)});
    check("state", {30'd0, bus.state}, m_state);
  endtask

  // mid: 0 nothing, 1 raise enc_busy mid-frame, 2 randomly perturb all decision inputs mid-frame.
  task automatic frame(input int vs_len, input int act_len, input int gap, input int mid);
    for (int i = 0; i < vs_len; i++) step(1'b0, 1'b1);
    for (int i = 0; i < act_len; i++) begin
      if (i == act_len / 2) begin
        if (mid == 1) begin
          bus.enc_busy = 1'b1;
        end else if (mid == 2) begin
          bus.enable     = ($urandom_range(0, 9) != 0);
          bus.div        = DIV_W'($urandom_range(0, 3));
          bus.enc_busy   = ($urandom_range(0, 3) == 0);
          bus.fifo_afull = ($urandom_range(0, 3) == 0);
        end
      end
      step(1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
    check("frame_cnt", {28'd0, bus.frame_cnt}, m_frames);
    check("drop_cnt", {28'd0, bus.drop_cnt}, m_drops);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.div        = '0;
    bus.enc_busy   = 1'b0;
    bus.fifo_afull = 1'b0;
    bus.pvalid_in  = 1'b0;
    bus.vsync_in   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pvalid_out", {31'd0, bus.pvalid_out}, 0);
    check("rst_vsync_out", {31'd0, bus.vsync_out}, 0);
    check("rst_state", {30'd0, bus.state}, 0);
    check("rst_frame_cnt", {28'd0, bus.frame_cnt}, 0);
    check("rst_drop_cnt", {28'd0, bus.drop_cnt}, 0);
    check("rst_sync_lost", {31'd0, bus.sync_lost}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // div=0: every frame forwarded
    bus.enable = 1'b1;
    bus.div    = 4'd0;
    for (int f = 0; f < 5; f++) frame(2, 6, 2, 0);
    check("div0_frames", {28'd0, bus.frame_cnt}, 5);
    check("div0_drops", {28'd0, bus.drop_cnt}, 0);

    // div=2: frames 1,4,7 of 9 forwarded
    do_reset();
    bus.div = 4'd2;
    for (int f = 0; f < 9; f++) frame(1, 5, 2, 0);
    check("div2_frames", {28'd0, bus.frame_cnt}, 3);

    // div=1 with afull over the first vrise
    do_reset();
    bus.div        = 4'd1;
    bus.fifo_afull = 1'b1;
    frame(2, 5, 2, 0);
    bus.fifo_afull = 1'b0;
    frame(2, 5, 2, 0);
    frame(2, 5, 2, 0);
    check("afull_drops", {28'd0, bus.drop_cnt}, 1);
    check("afull_frames", {28'd0, bus.frame_cnt}, 1);

    // enc_busy rises mid-PASS frame, still busy at next vrise
    do_reset();
    bus.div = 4'd0;
    frame(2, 8, 2, 1);
    frame(2, 8, 2, 0);
    check("busy_frames", {28'd0, bus.frame_cnt}, 1);
    check("busy_drops", {28'd0, bus.drop_cnt}, 1);
    bus.enc_busy = 1'b0;

    // reset pulsed mid-PASS frame while vsync_in is high
    do_reset();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("pre_rst_frame_cnt", {28'd0, bus.frame_cnt}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pvalid_out", {31'd0, bus.pvalid_out}, 0);
    check("async_vsync_out", {31'd0, bus.vsync_out}, 0);
    check("async_state", {30'd0, bus.state}, 0);
    check("async_frame_cnt", {28'd0, bus.frame_cnt}, 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    frame(2, 5, 2, 0);
    check("post_rst_frames", {28'd0, bus.frame_cnt}, 1);

    // div lowered below the current phase wraps on the next vrise
    do_reset();
    bus.div = 4'd3;
    frame(1, 4, 2, 0);
    frame(1, 4, 2, 0);
    bus.div = 4'd1;
    frame(1, 4, 2, 0);
    frame(1, 4, 2, 0);
    check("wrap_frames", {28'd0, bus.frame_cnt}, 2);

    // counter saturation
    do_reset();
    bus.div = 4'd0;
    for (int f = 0; f < 18; f++) frame(1, 3, 1, 0);
    check("sat_frames", {28'd0, bus.frame_cnt}, CNT_MAX);
    bus.enc_busy = 1'b1;
    for (int f = 0; f < 18; f++) frame(1, 3, 1, 0);
    check("sat_drops", {28'd0, bus.drop_cnt}, CNT_MAX);
    check("sat_frames_held", {28'd0, bus.frame_cnt}, CNT_MAX);
    bus.enc_busy = 1'b0;

    // randomized frames with mid-frame perturbations
    do_reset();
    for (int f = 0; f < 90; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.enable     = ($urandom_range(0, 7) != 0);
        bus.div        = DIV_W'($urandom_range(0, 3));
        bus.enc_busy   = ($urandom_range(0, 3) == 0);
        bus.fifo_afull = ($urandom_range(0, 4) == 0);
      end
      frame($urandom_range(1, 4), $urandom_range(2, 9), $urandom_range(1, 3),
            ($urandom_range(0, 1) == 1) ? 2 : 0);
    end
    check("end_sync_lost", {31'd0, bus.sync_lost}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
